// File: rtl/regfile_pkg.sv
// Shared defaults and word types for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned RF_WIDTH = 32;
    localparam int unsigned RF_DEPTH = 32;
    localparam int unsigned RF_AW    = $clog2(RF_DEPTH);

    typedef logic [RF_AW-1:0]    rf_addr_t;
    typedef logic [RF_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending (busy) bits with a registered population count.
// Callers qualify set/clr addresses; flush clears everything and beats set.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr,
    input  logic [AW-1:0]    clr_addr,
    input  logic             flush,
    output logic [DEPTH-1:0] busy,
    output logic [AW:0]      count
);

    logic [DEPTH-1:0] busy_d, busy_q;
    logic [AW:0]      count_d, count_q;

    // Next busy vector: clear on write, set on issue (issue wins), flush clears all.
    // Count is taken from the next vector so it always matches the registered bits.
    always_comb begin
        busy_d = busy_q;
        if (clr) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set) begin
            busy_d[set_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        count_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_d = count_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    // State update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy  = busy_q;
    assign count = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read register file with optional hardwired zero register,
// write-to-read bypass and a pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [AW-1:0]               wa,
    input  logic [WIDTH-1:0]            wd,
    input  logic [NREAD-1:0][AW-1:0]    ra,
    output logic [NREAD-1:0][WIDTH-1:0] rd,
    output logic [NREAD-1:0]            rbusy,
    input  logic                        iss,
    input  logic [AW-1:0]               iss_addr,
    input  logic                        flush,
    output logic [AW:0]                 pend_cnt
);

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] rf_d [DEPTH];
    logic [WIDTH-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             wr_en;
    logic             set_en;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_C;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Qualified write and issue strobes: out-of-range and hardwired-zero targets are dropped.
    always_comb begin
        wr_en  = we  && in_range(wa)       && !is_zero_reg(wa);
        set_en = iss && in_range(iss_addr) && !is_zero_reg(iss_addr);
    end

    // Next storage contents.
    always_comb begin
        rf_d = rf_q;
        if (wr_en) begin
            rf_d[wa] = wd;
        end
    end

    // Storage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_q <= '{default: '0};
        end else begin
            rf_q <= rf_d;
        end
    end

    // Combinational read ports with same-cycle write forwarding and busy masking.
    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            if (in_range(ra[i]) && !is_zero_reg(ra[i])) begin
                if ((BYPASS != 0) && wr_en && (wa == ra[i])) begin
                    rd[i] = wd;
                end else begin
                    rd[i] = rf_q[ra[i]];
                end
            end
            if (in_range(ra[i])) begin
                rbusy[i] = busy[ra[i]] && !((BYPASS != 0) && we && (wa == ra[i]));
            end
        end
    end

    rf_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set      (set_en),
        .set_addr (iss_addr),
        .clr      (wr_en),
        .clr_addr (wa),
        .flush    (flush),
        .busy     (busy),
        .count    (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb; one bypassing and one
// non-bypassing instance share stimulus and a behavioural reference model.
module tb_regfile_sb;

    logic            clk = 1'b0;
    logic            reset;
    logic            we;
    logic [4:0]      wa;
    logic [31:0]     wd;
    logic [1:0][4:0] ra;
    logic            iss;
    logic [4:0]      iss_addr;
    logic            flush;

    logic [1:0][31:0] rd_b, rd_n;
    logic [1:0]       rb_b, rb_n;
    logic [5:0]       pc_b, pc_n;

    // Reference model state
    bit [31:0] m_rf [32];
    bit [31:0] m_busy;

    // Values sampled at the negedge of the most recent tick
    logic [1:0][31:0] s_rd_b, s_rd_n;
    logic [1:0]       s_rb_b, s_rb_n;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(
        .WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_byp (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd_b), .rbusy(rb_b), .iss(iss), .iss_addr(iss_addr),
        .flush(flush), .pend_cnt(pc_b)
    );

    regfile_sb #(
        .WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(0)
    ) dut_nobyp (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd_n), .rbusy(rb_n), .iss(iss), .iss_addr(iss_addr),
        .flush(flush), .pend_cnt(pc_n)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected read data: register 0 reads zero; a bypassing port sees this cycle's write.
    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (byp && we && wa == a) return wd;
        return m_rf[a];
    endfunction

    function automatic logic exp_rbusy(input bit byp, input logic [4:0] a);
        return m_busy[a] && !(byp && we && wa == a);
    endfunction

    task automatic idle();
        reset    = 1'b1;
        we       = 1'b0;
        wa       = '0;
        wd       = '0;
        ra       = '0;
        iss      = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
    endtask

    // One clock: compare combinational outputs mid-cycle, advance the model
    // at the edge, then compare the registered pending count.
    task automatic tick();
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            check_eq($sformatf("rd%0d_byp", p),    rd_b[p], exp_rd(1'b1, ra[p]));
            check_eq($sformatf("rd%0d_nobyp", p),  rd_n[p], exp_rd(1'b0, ra[p]));
            check_eq($sformatf("rbusy%0d_byp", p), rb_b[p], exp_rbusy(1'b1, ra[p]));
            check_eq($sformatf("rbusy%0d_nobyp", p), rb_n[p], exp_rbusy(1'b0, ra[p]));
        end
        s_rd_b = rd_b; s_rd_n = rd_n; s_rb_b = rb_b; s_rb_n = rb_n;
        @(posedge clk);
        if (!reset) begin
            m_rf   = '{default: '0};
            m_busy = '0;
        end else begin
            if (we && wa != 5'd0) m_rf[wa] = wd;
            if (we) m_busy[wa] = 1'b0;
            if (iss && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
            if (flush) m_busy = '0;
        end
        #1;
        check_eq("pend_cnt_byp",   pc_b, $countones(m_busy));
        check_eq("pend_cnt_nobyp", pc_n, $countones(m_busy));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        // Reset held for two cycles before the model starts tracking.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_rf   = '{default: '0};
        m_busy = '0;
        check_eq("reset_pend_byp", pc_b, 6'd0);
        check_eq("reset_pend_nobyp", pc_n, 6'd0);
        idle();

        // Every address reads zero and not busy after reset.
        for (int k = 0; k < 16; k++) begin
            idle();
            ra[0] = 5'(2 * k);
            ra[1] = 5'(2 * k + 1);
            tick();
            check_eq("post_reset_rd1", s_rd_b[1], 32'd0);
            check_eq("post_reset_rbusy", {30'd0, s_rb_b}, 32'd0);
        end

        // Same-cycle write forwarding versus registered visibility.
        idle(); we = 1; wa = 5; wd = 32'h1111_1111; tick();
        idle(); we = 1; wa = 5; wd = 32'hDEAD_BEEF; ra[0] = 5; tick();
        check_eq("bypass_same_cycle", s_rd_b[0], 32'hDEAD_BEEF);
        check_eq("nobypass_old_value", s_rd_n[0], 32'h1111_1111);
        idle(); ra[0] = 5; tick();
        check_eq("nobypass_next_cycle", s_rd_n[0], 32'hDEAD_BEEF);

        // Register 0 stays zero and never goes pending.
        idle(); we = 1; wa = 0; wd = 32'h1234; ra[0] = 0; tick();
        check_eq("zero_reg_write_cycle", s_rd_b[0], 32'd0);
        idle(); ra[1] = 0; tick();
        check_eq("zero_reg_after", s_rd_n[1], 32'd0);
        idle(); iss = 1; iss_addr = 0; tick();
        check_eq("zero_reg_iss_pend", pc_b, 6'd0);

        // Issue three registers, then retire one by writing it.
        idle(); iss = 1; iss_addr = 3; tick();
        idle(); iss = 1; iss_addr = 7; tick();
        idle(); iss = 1; iss_addr = 9; tick();
        check_eq("pend_three", pc_b, 6'd3);
        idle(); ra[0] = 7; tick();
        check_eq("rbusy_pending7", s_rb_b[0], 1'b1);
        idle(); we = 1; wa = 7; wd = 32'h7777; ra[0] = 7; tick();
        check_eq("rbusy_write_cycle_byp", s_rb_b[0], 1'b0);
        check_eq("rbusy_write_cycle_nobyp", s_rb_n[0], 1'b1);
        check_eq("pend_after_write", pc_b, 6'd2);

        // Issue and write on the same register: issue wins. Then flush beats issue.
        idle(); iss = 1; iss_addr = 4; we = 1; wa = 4; wd = 32'h4444; tick();
        check_eq("iss_we_same_pend", pc_b, 6'd3);
        idle(); ra[0] = 4; tick();
        check_eq("iss_we_same_busy", s_rb_b[0], 1'b1);
        idle(); flush = 1; iss = 1; iss_addr = 6; we = 1; wa = 8; wd = 32'h8888; tick();
        check_eq("flush_pend", pc_b, 6'd0);
        idle(); ra[0] = 8; tick();
        check_eq("flush_write_kept", s_rd_n[0], 32'h8888);

        // Re-issue an already-busy register: count unchanged.
        idle(); iss = 1; iss_addr = 12; tick();
        idle(); iss = 1; iss_addr = 12; tick();
        check_eq("reissue_pend", pc_b, 6'd1);

        // Reset with four registers pending discards marks and data.
        idle(); flush = 1; tick();
        for (int k = 0; k < 4; k++) begin
            idle(); iss = 1; iss_addr = 5'(k + 1); tick();
        end
        check_eq("pend_four", pc_b, 6'd4);
        idle(); reset = 0; we = 1; wa = 2; wd = 32'hFFFF; iss = 1; iss_addr = 20; tick();
        check_eq("mid_reset_pend", pc_b, 6'd0);
        idle(); ra[0] = 5; ra[1] = 2; tick();
        check_eq("mid_reset_rd0", s_rd_b[0], 32'd0);
        check_eq("mid_reset_rd1", s_rd_n[1], 32'd0);
        idle(); we = 1; wa = 1; wd = 32'hABCD; tick();
        check_eq("plain_write_after_reset", pc_b, 6'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            idle();
            reset    = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            we       = 1'($urandom_range(0, 1));
            wa       = 5'($urandom_range(0, 31));
            wd       = $urandom;
            iss      = ($urandom_range(0, 99) < 40);
            iss_addr = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            flush    = ($urandom_range(0, 99) < 5);
            for (int p = 0; p < 2; p++) begin
                ra[p] = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
